// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg
// Shared constants, beat field layout and state/leg encodings for the
// arbitrage order path (egress transmitter and ingress book parser).
// Revision: 1.0
// ============================================================================
package arb_pkg;

    localparam int          BEAT_W        = 512;
    localparam logic [31:0] MSG_NEW_ORDER = 32'h0000_0010;

    localparam logic [31:0] EXCH_BINANCE  = 32'd1;
    localparam logic [31:0] EXCH_COINBASE = 32'd2;
    localparam logic [31:0] EXCH_OKX      = 32'd3;

    // Header beat fields (32-bit each)
    localparam int HDR_MSG_LSB    = 0;
    localparam int HDR_SYM_LSB    = 32;
    localparam int HDR_EXCH_LSB   = 64;
    localparam int HDR_SEQ_LSB    = 96;

    // Body beat fields: price/qty are 64-bit slots, seq is 32-bit
    localparam int BODY_PRICE_LSB = 64;
    localparam int BODY_QTY_LSB   = 128;
    localparam int BODY_SIDE_BIT  = 192;
    localparam int BODY_SEQ_LSB   = 224;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    typedef enum logic {
        LEG_SELL = 1'b0,
        LEG_BUY  = 1'b1
    } leg_t;

endpackage
`default_nettype wire

// File: rtl/order_beat_formatter.sv
`default_nettype none
// ============================================================================
// order_beat_formatter
// Combinational builder of the NEW_ORDER header/body beats for one leg.
// Revision: 1.0
// ============================================================================
module order_beat_formatter
    import arb_pkg::*;
#(
    parameter int PRICE_WIDTH  = 64,
    parameter int QTY_WIDTH    = 64,
    parameter int SYMBOL_WIDTH = 32
) (
    input  logic                    is_body,
    input  logic                    leg_buy,
    input  logic [SYMBOL_WIDTH-1:0] symbol,
    input  logic [31:0]             buy_exch,
    input  logic [31:0]             sell_exch,
    input  logic [PRICE_WIDTH-1:0]  buy_price,
    input  logic [PRICE_WIDTH-1:0]  sell_price,
    input  logic [QTY_WIDTH-1:0]    qty,
    input  logic [31:0]             seq,
    output logic [BEAT_W-1:0]       beat
);

    always_comb begin
        beat = '0;
        if (is_body) begin
            beat[BODY_PRICE_LSB +: 64] = leg_buy ? 64'(buy_price) : 64'(sell_price);
            beat[BODY_QTY_LSB   +: 64] = 64'(qty);
            beat[BODY_SIDE_BIT]        = leg_buy;
            beat[BODY_SEQ_LSB   +: 32] = seq;
        end else begin
            beat[HDR_MSG_LSB  +: 32] = MSG_NEW_ORDER;
            beat[HDR_SYM_LSB  +: 32] = 32'(symbol);
            beat[HDR_EXCH_LSB +: 32] = leg_buy ? buy_exch : sell_exch;
            beat[HDR_SEQ_LSB  +: 32] = seq;
        end
    end

endmodule
`default_nettype wire

// File: rtl/order_entry_transmitter.sv
`default_nettype none
// ============================================================================
// order_entry_transmitter
// Serialises one arbitrage request into buy and sell NEW_ORDER packets on
// the 512-bit TX stream, with inter-packet gap and risk-kill flush.
// Revision: 1.0
// ============================================================================
module order_entry_transmitter
    import arb_pkg::*;
#(
    parameter int PRICE_WIDTH  = 64,
    parameter int QTY_WIDTH    = 64,
    parameter int SYMBOL_WIDTH = 32,
    parameter int MIN_GAP      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SYMBOL_WIDTH-1:0] req_symbol,
    input  logic [31:0]             req_buy_exch,
    input  logic [31:0]             req_sell_exch,
    input  logic [PRICE_WIDTH-1:0]  req_buy_price,
    input  logic [PRICE_WIDTH-1:0]  req_sell_price,
    input  logic [QTY_WIDTH-1:0]    req_qty,
    input  logic                    flush,
    output logic [511:0]            tx_data,
    output logic                    tx_valid,
    output logic                    tx_sop,
    output logic                    tx_eop,
    input  logic                    tx_ready,
    output logic [63:0]             orders_sent,
    output logic [63:0]             orders_aborted
);

    localparam int              GAP_W      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam bit              C_HAS_GAP  = (MIN_GAP > 0);
    localparam logic [GAP_W-1:0] C_GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

    tx_state_t               r_state;
    tx_state_t               w_state_next;
    leg_t                    r_leg;
    logic                    r_out_en;
    logic                    r_abort_pend;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [31:0]             r_seq;
    logic [63:0]             r_sent;
    logic [63:0]             r_aborted;
    logic [SYMBOL_WIDTH-1:0] r_symbol;
    logic [31:0]             r_buy_exch;
    logic [31:0]             r_sell_exch;
    logic [PRICE_WIDTH-1:0]  r_buy_price;
    logic [PRICE_WIDTH-1:0]  r_sell_price;
    logic [QTY_WIDTH-1:0]    r_qty;

    logic                    w_accept;
    logic                    w_eop_acc;
    logic                    w_sell_next;
    logic                    w_new_abort;
    logic [BEAT_W-1:0]       w_beat;

    assign w_accept    = req_valid && req_ready;
    assign w_eop_acc   = (r_state == ST_BODY) && tx_ready;
    assign w_sell_next = (r_leg == LEG_BUY) && !r_abort_pend && !flush;
    // Only the first flush seen while a buy leg is outstanding cancels its sell leg
    assign w_new_abort = flush && (r_leg == LEG_BUY) && (r_state != ST_IDLE) && !r_abort_pend;

    order_beat_formatter #(
        .PRICE_WIDTH  (PRICE_WIDTH),
        .QTY_WIDTH    (QTY_WIDTH),
        .SYMBOL_WIDTH (SYMBOL_WIDTH)
    ) u_fmt (
        .is_body    (r_state == ST_BODY),
        .leg_buy    (r_leg == LEG_BUY),
        .symbol     (r_symbol),
        .buy_exch   (r_buy_exch),
        .sell_exch  (r_sell_exch),
        .buy_price  (r_buy_price),
        .sell_price (r_sell_price),
        .qty        (r_qty),
        .seq        (r_seq),
        .beat       (w_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_HDR;
            ST_HDR:  if (tx_ready) w_state_next = ST_BODY;
            ST_BODY: begin
                if (tx_ready) begin
                    if (C_HAS_GAP)        w_state_next = ST_GAP;
                    else if (w_sell_next) w_state_next = ST_HDR;
                    else                  w_state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                // A live flush after the buy leg abandons the rest of the gap
                if ((r_leg == LEG_BUY) && flush) w_state_next = ST_IDLE;
                else if (r_gap_cnt == '0)        w_state_next = w_sell_next ? ST_HDR : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        tx_data   = '0;
        req_ready = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = r_out_en && !flush;
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_sop   = 1'b1;
                tx_data  = w_beat;
            end
            ST_BODY: begin
                tx_valid = 1'b1;
                tx_eop   = 1'b1;
                tx_data  = w_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_en     <= 1'b0;
            r_leg        <= LEG_BUY;
            r_abort_pend <= 1'b0;
            r_gap_cnt    <= '0;
            r_seq        <= '0;
            r_sent       <= '0;
            r_aborted    <= '0;
            r_symbol     <= '0;
            r_buy_exch   <= '0;
            r_sell_exch  <= '0;
            r_buy_price  <= '0;
            r_sell_price <= '0;
            r_qty        <= '0;
        end else begin
            r_out_en <= 1'b1;

            if (w_accept) begin
                r_symbol     <= req_symbol;
                r_buy_exch   <= req_buy_exch;
                r_sell_exch  <= req_sell_exch;
                r_buy_price  <= req_buy_price;
                r_sell_price <= req_sell_price;
                r_qty        <= req_qty;
                r_leg        <= LEG_BUY;
            end else if ((w_state_next == ST_HDR) && (r_state != ST_HDR)) begin
                r_leg <= LEG_SELL;
            end

            if (w_eop_acc) begin
                r_seq     <= r_seq + 32'd1;
                r_gap_cnt <= C_GAP_LOAD;
                if (r_sent != '1) r_sent <= r_sent + 64'd1;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_abort_pend <= 1'b0;
            end else if (w_new_abort) begin
                r_abort_pend <= 1'b1;
                if (r_aborted != '1) r_aborted <= r_aborted + 64'd1;
            end
        end
    end

    assign orders_sent    = r_sent;
    assign orders_aborted = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_order_entry_transmitter.sv
`default_nettype none
// ============================================================================
// tb_order_entry_transmitter
// Scoreboard bench: instance a uses MIN_GAP=4, instance b uses MIN_GAP=0.
// Revision: 1.0
// ============================================================================
module tb_order_entry_transmitter;

    typedef struct {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        int           idle;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_req_valid = 0, a_req_ready, a_flush = 0, a_tx_ready = 1;
    logic [31:0]  a_sym = 0, a_be = 0, a_se = 0;
    logic [63:0]  a_bp = 0, a_sp = 0, a_q = 0;
    logic [511:0] a_tx_data;
    logic         a_tx_valid, a_tx_sop, a_tx_eop;
    logic [63:0]  a_sent, a_aborted;

    logic         b_req_valid = 0, b_req_ready, b_flush = 0, b_tx_ready = 1;
    logic [31:0]  b_sym = 0, b_be = 0, b_se = 0;
    logic [63:0]  b_bp = 0, b_sp = 0, b_q = 0;
    logic [511:0] b_tx_data;
    logic         b_tx_valid, b_tx_sop, b_tx_eop;
    logic [63:0]  b_sent, b_aborted;

    order_entry_transmitter #(.MIN_GAP(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_symbol(a_sym), .req_buy_exch(a_be), .req_sell_exch(a_se),
        .req_buy_price(a_bp), .req_sell_price(a_sp), .req_qty(a_q), .flush(a_flush),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_sop(a_tx_sop), .tx_eop(a_tx_eop),
        .tx_ready(a_tx_ready), .orders_sent(a_sent), .orders_aborted(a_aborted)
    );

    order_entry_transmitter #(.MIN_GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_symbol(b_sym), .req_buy_exch(b_be), .req_sell_exch(b_se),
        .req_buy_price(b_bp), .req_sell_price(b_sp), .req_qty(b_q), .flush(b_flush),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_sop(b_tx_sop), .tx_eop(b_tx_eop),
        .tx_ready(b_tx_ready), .orders_sent(b_sent), .orders_aborted(b_aborted)
    );

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] es[2];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_hdr(input logic [31:0] sym, input logic [31:0] exch,
                                            input logic [31:0] seq);
        logic [511:0] d;
        d = '0;
        d[31:0]   = 32'h10;
        d[63:32]  = sym;
        d[95:64]  = exch;
        d[127:96] = seq;
        return d;
    endfunction

    function automatic logic [511:0] mk_body(input logic [63:0] price, input logic [63:0] qty,
                                             input logic side, input logic [31:0] seq);
        logic [511:0] d;
        d = '0;
        d[127:64]  = price;
        d[191:128] = qty;
        d[192]     = side;
        d[255:224] = seq;
        return d;
    endfunction

    task automatic push(input int id, input logic [511:0] d, input logic sop, input logic eop,
                        input int idle);
        exp_t e;
        e.data = d; e.sop = sop; e.eop = eop; e.idle = idle;
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
    endtask

    task automatic mon(input int id);
        exp_t         e;
        int           idle = 0;
        logic         held = 0;
        logic [511:0] hd, d;
        logic         hs, he, v, r, s, eo;
        string        nm;
        nm = (id == 0) ? "a" : "b";
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idle = 0;
                held = 0;
                continue;
            end
            d  = (id == 0) ? a_tx_data  : b_tx_data;
            v  = (id == 0) ? a_tx_valid : b_tx_valid;
            r  = (id == 0) ? a_tx_ready : b_tx_ready;
            s  = (id == 0) ? a_tx_sop   : b_tx_sop;
            eo = (id == 0) ? a_tx_eop   : b_tx_eop;
            if (held) begin
                chk({nm, "_hold_valid"}, 64'(v), 64'd1);
                chkw({nm, "_hold_data"}, d, hd);
                chk({nm, "_hold_flags"}, {62'd0, s, eo}, {62'd0, hs, he});
            end
            if (v && r) begin
                if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_unexpected_beat: got sop=%0b eop=%0b data=%h expected none",
                             nm, s, eo, d);
                end else begin
                    e = (id == 0) ? qa.pop_front() : qb.pop_front();
                    chkw({nm, "_beat_data"}, d, e.data);
                    chk({nm, "_beat_flags"}, {62'd0, s, eo}, {62'd0, e.sop, e.eop});
                    if (e.idle >= 0) chk({nm, "_idle_before"}, 64'(idle), 64'(e.idle));
                end
                idle = 0;
                held = 0;
            end else if (v) begin
                held = 1; hd = d; hs = s; he = eo;
            end else begin
                idle++;
                held = 0;
            end
        end
    endtask

    // Issue one request; push its expected beats before it is accepted.
    task automatic req(input int id, input logic [31:0] sym, input logic [31:0] be,
                       input logic [31:0] se, input logic [63:0] bp, input logic [63:0] sp,
                       input logic [63:0] q, input int hdr_idle, input bit sell);
        bit ok = 0;
        push(id, mk_hdr(sym, be, es[id]), 1, 0, hdr_idle);
        push(id, mk_body(bp, q, 1'b1, es[id]), 0, 1, 0);
        if (sell) begin
            push(id, mk_hdr(sym, se, es[id] + 32'd1), 1, 0, (id == 0) ? 4 : 0);
            push(id, mk_body(sp, q, 1'b0, es[id] + 32'd1), 0, 1, 0);
            es[id] = es[id] + 32'd2;
        end else begin
            es[id] = es[id] + 32'd1;
        end
        @(negedge clk);
        if (id == 0) begin
            a_sym = sym; a_be = be; a_se = se; a_bp = bp; a_sp = sp; a_q = q; a_req_valid = 1;
        end else begin
            b_sym = sym; b_be = be; b_se = se; b_bp = bp; b_sp = sp; b_q = q; b_req_valid = 1;
        end
        for (int n = 0; n < 300; n++) begin
            if ((id == 0) ? a_req_ready : b_req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL req_accept_timeout: got no req_ready expected req_ready within 300 cycles");
        end
        @(posedge clk);
        #1;
        if (id == 0) a_req_valid = 0;
        else         b_req_valid = 0;
    endtask

    task automatic wait_empty(input int id);
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            #1;
            if (((id == 0) ? qa.size() : qb.size()) == 0) return;
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d beats outstanding expected 0",
                 (id == 0) ? qa.size() : qb.size());
    endtask

    task automatic count_until_ready(input int id, input int exp_cycles);
        int cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            cnt++;
            if ((id == 0) ? a_req_ready : b_req_ready) break;
        end
        chk("ready_after_abort", 64'(cnt), 64'(exp_cycles));
    endtask

    task automatic wait_buy_body();
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (a_tx_valid && a_tx_eop) return;
        end
        tests++;
        fails++;
        $display("FAIL body_timeout: got no BODY beat expected BODY within 50 cycles");
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        es[0] = 0;
        es[1] = 0;
        fork
            mon(0);
            mon(1);
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 64'(a_tx_valid), 64'd0);
        chkw("rst_tx_data", a_tx_data, 512'd0);
        chk("rst_req_ready", 64'(a_req_ready), 64'd0);
        chk("rst_counters", a_sent | a_aborted, 64'd0);
        rst_n = 1;

        // Single request, four beats with a 4-cycle gap between packets
        req(0, 32'h42, 32'd1, 32'd2, 64'd1000, 64'd1012, 64'd5, -1, 1);
        wait_empty(0);
        repeat (6) @(negedge clk);
        chk("t1_orders_sent", a_sent, 64'd2);
        chk("t1_orders_aborted", a_aborted, 64'd0);

        // Backpressure during the buy BODY
        req(0, 32'h77, 32'd3, 32'd1, 64'h1234_5678_9abc_def0, 64'hfedc_ba98_7654_3210, 64'd9, -1, 1);
        wait_buy_body();
        a_tx_ready = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t2_req_ready_bp", 64'(a_req_ready), 64'd0);
        end
        a_tx_ready = 1;
        wait_empty(0);
        repeat (6) @(negedge clk);
        chk("t2_orders_sent", a_sent, 64'd4);

        // Flush during buy HDR cancels the sell leg; ready once the gap ends
        req(0, 32'h55, 32'd2, 32'd3, 64'd200, 64'd210, 64'd1, -1, 0);
        a_flush = 1;
        @(posedge clk);
        #1;
        a_flush = 0;
        wait_empty(0);
        count_until_ready(0, 5);
        chk("t3_orders_aborted", a_aborted, 64'd1);
        chk("t3_orders_sent", a_sent, 64'd5);

        // Sequence wrap
        @(negedge clk);
        force dut_a.r_seq = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut_a.r_seq;
        es[0] = 32'hFFFF_FFFF;
        req(0, 32'h99, 32'd1, 32'd3, 64'd7, 64'd8, 64'd2, -1, 1);
        wait_empty(0);
        repeat (6) @(negedge clk);
        chk("t4_orders_sent", a_sent, 64'd7);

        // Asynchronous reset while the buy BODY is stalled
        req(0, 32'h11, 32'd1, 32'd2, 64'd50, 64'd60, 64'd3, -1, 1);
        wait_buy_body();
        a_tx_ready = 0;
        #3;
        rst_n = 0;
        #1;
        chk("t5_tx_valid_async", 64'(a_tx_valid), 64'd0);
        chk("t5_orders_sent", a_sent, 64'd0);
        chk("t5_orders_aborted", a_aborted, 64'd0);
        qa.delete();
        es[0] = 0;
        es[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        a_tx_ready = 1;
        req(0, 32'h12, 32'd2, 32'd1, 64'd70, 64'd80, 64'd4, -1, 1);
        wait_empty(0);
        repeat (6) @(negedge clk);
        chk("t5_sent_after_reset", a_sent, 64'd2);

        // MIN_GAP=0: back-to-back packets, one IDLE cycle between requests
        req(1, 32'h21, 32'd1, 32'd2, 64'd100, 64'd101, 64'd10, -1, 1);
        req(1, 32'h22, 32'd2, 32'd3, 64'd200, 64'd202, 64'd20, 1, 1);
        req(1, 32'h23, 32'd3, 32'd1, 64'd300, 64'd303, 64'd30, 1, 1);
        wait_empty(1);
        repeat (3) @(negedge clk);
        chk("t6_orders_sent", b_sent, 64'd6);

        // MIN_GAP=0 flush: ready one cycle after the buy EOP
        req(1, 32'h24, 32'd1, 32'd2, 64'd400, 64'd404, 64'd40, -1, 0);
        b_flush = 1;
        @(posedge clk);
        #1;
        b_flush = 0;
        wait_empty(1);
        count_until_ready(1, 1);
        chk("t6_orders_aborted", b_aborted, 64'd1);
        chk("t6_sent_after_abort", b_sent, 64'd7);

        repeat (10) @(negedge clk);
        chk("final_a_queue", 64'(qa.size()), 64'd0);
        chk("final_b_queue", 64'(qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
